// File: rtl/gate_pkg.sv
// gate_pkg: shared types and constants for the gate dead-time controller.
//   phase_state_e : per-phase FSM state (OFF, DEAD, HIGH, LOW)
//   req_e         : decoded per-phase request, encoded as {hi,lo}
//   GATE_HI_BIT / GATE_LO_BIT : bit positions inside a 2-bit phase slice
package gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } phase_state_e;

  // Encoding matches the raw {hi,lo} request bits, so decode is a plain cast.
  typedef enum logic [1:0] {
    REQ_OFF     = 2'b00,
    REQ_LOW     = 2'b01,
    REQ_HIGH    = 2'b10,
    REQ_ILLEGAL = 2'b11
  } req_e;

  localparam int unsigned GATE_HI_BIT = 1;
  localparam int unsigned GATE_LO_BIT = 0;

  function automatic req_e decode_req(input logic [1:0] raw);
    return req_e'(raw);
  endfunction

endpackage

// File: rtl/phase_deadtime.sv
// phase_deadtime: one half-bridge phase with break-before-make dead-time.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_req[1:0]       : {hi,lo} request for this phase
//   i_deadtime       : dead-time in cycles, sampled only when DEAD is entered
//   i_enable         : low drives the phase towards OFF (through DEAD if on)
//   i_fault_clr      : clears the sticky illegal-request flag
//   o_gate[1:0]      : registered {hi,lo} gate drive
//   o_fault          : sticky flag, set when {hi,lo}=11 is requested
//   o_ready          : low exactly while the phase is in DEAD
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | both gates off, may switch straight to HIGH/LOW
// DEAD  | both gates off, counting down the dead-time before new target
// HIGH  | high-side gate on
// LOW   | low-side gate on
module phase_deadtime
  import gate_pkg::*;
#(
  parameter int K_DTRES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req,
  input  logic [K_DTRES-1:0] i_deadtime,
  input  logic               i_enable,
  input  logic               i_fault_clr,
  output logic [1:0]         o_gate,
  output logic               o_fault,
  output logic               o_ready
);

  localparam logic [K_DTRES-1:0] CNT_ONE = K_DTRES'(1);

  phase_state_e       state_q, state_d;
  logic [K_DTRES-1:0] cnt_q, cnt_d;
  logic [1:0]         gate_q, gate_d;
  logic               fault_q, fault_d;

  req_e         req;
  phase_state_e target;

  always_comb begin
    req = decode_req(i_req);

    // Illegal and disabled requests both collapse to OFF.
    target = ST_OFF;
    if (i_enable) begin
      if (req == REQ_HIGH) begin
        target = ST_HIGH;
      end else if (req == REQ_LOW) begin
        target = ST_LOW;
      end
    end

    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_OFF: begin
        state_d = target;
      end
      ST_HIGH, ST_LOW: begin
        if (target != state_q) begin
          state_d = ST_DEAD;
          cnt_d   = (i_deadtime == '0) ? CNT_ONE : i_deadtime;
        end
      end
      ST_DEAD: begin
        // Leave on the edge after count 1; the target is whatever is
        // requested at that moment, so mid-dead changes never restart.
        if (cnt_q <= CNT_ONE) begin
          state_d = target;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    // Gates follow the next state so o_gate is a clean register output.
    gate_d = 2'b00;
    if (state_d == ST_HIGH) begin
      gate_d[GATE_HI_BIT] = 1'b1;
    end else if (state_d == ST_LOW) begin
      gate_d[GATE_LO_BIT] = 1'b1;
    end

    // A new illegal request wins over a simultaneous clear.
    fault_d = fault_q;
    if (req == REQ_ILLEGAL) begin
      fault_d = 1'b1;
    end else if (i_fault_clr) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      gate_q  <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      fault_q <= fault_d;
    end
  end

  assign o_gate  = gate_q;
  assign o_fault = fault_q;
  assign o_ready = (state_q != ST_DEAD);

endmodule

// File: rtl/gate_deadtime.sv
// gate_deadtime: multi-phase gate driver with per-phase dead-time insertion.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_cmd          : commutation command, bit 2k+1 = hi of phase k, 2k = lo
//   i_deadtime     : dead-time in cycles (0 behaves as 1), shared by phases
//   i_enable       : low forces all phases towards OFF
//   i_fault_clr    : single-cycle clear of the sticky per-phase faults
//   o_gate         : registered gate drive, same bit mapping as i_cmd
//   o_fault        : per-phase sticky illegal-request flag
//   o_ready        : per-phase, low while in dead-time
module gate_deadtime
  import gate_pkg::*;
#(
  parameter int K_DTRES  = 8,
  parameter int K_NPHASE = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2*K_NPHASE-1:0] i_cmd,
  input  logic [K_DTRES-1:0]    i_deadtime,
  input  logic                  i_enable,
  input  logic                  i_fault_clr,
  output logic [2*K_NPHASE-1:0] o_gate,
  output logic [K_NPHASE-1:0]   o_fault,
  output logic [K_NPHASE-1:0]   o_ready
);

  for (genvar g = 0; g < K_NPHASE; g++) begin : g_phase
    phase_deadtime #(
      .K_DTRES(K_DTRES)
    ) u_phase (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_cmd[2*g+1:2*g]),
      .i_deadtime  (i_deadtime),
      .i_enable    (i_enable),
      .i_fault_clr (i_fault_clr),
      .o_gate      (o_gate[2*g+1:2*g]),
      .o_fault     (o_fault[g]),
      .o_ready     (o_ready[g])
    );
  end

endmodule

// File: tb/tb_gate_deadtime.sv
module tb_gate_deadtime;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_cmd;
  logic [7:0] i_deadtime;
  logic       i_enable;
  logic       i_fault_clr;
  logic [5:0] o_gate;
  logic [2:0] o_fault;
  logic [2:0] o_ready;

  int n_cmp;
  int n_bad;

  gate_deadtime #(.K_DTRES(8), .K_NPHASE(3)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd       (i_cmd),
    .i_deadtime  (i_deadtime),
    .i_enable    (i_enable),
    .i_fault_clr (i_fault_clr),
    .o_gate      (o_gate),
    .o_fault     (o_fault),
    .o_ready     (o_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
    n_cmp++;
    if (o_gate !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_gate: got %b want %b", o_gate, 6'b0);
    end
    n_cmp++;
    if (o_fault !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_fault: got %b want %b", o_fault, 3'b000);
    end
    n_cmp++;
    if (o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want %b", o_ready, 3'b111);
    end
  endtask

  task automatic test_basic_switch();
    i_deadtime = 8'd5;
    i_cmd = 6'b000010;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000010) begin
      n_bad++;
      $display("FAIL basic_high: got %b want %b", o_gate, 6'b000010);
    end
    i_cmd = 6'b000001;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_cmp++;
      if (o_gate !== 6'b000000 || o_ready !== 3'b110) begin
        n_bad++;
        $display("FAIL basic_dead[%0d]: got gate %b ready %b want 000000 110", i, o_gate, o_ready);
      end
    end
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000001 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL basic_low: got gate %b ready %b want 000001 111", o_gate, o_ready);
    end
  endtask

  task automatic test_zero_deadtime();
    i_deadtime = 8'd0;
    i_cmd = 6'b000010;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b110) begin
      n_bad++;
      $display("FAIL zero_dead_a: got gate %b ready %b want 000000 110", o_gate, o_ready);
    end
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000010) begin
      n_bad++;
      $display("FAIL zero_high: got %b want %b", o_gate, 6'b000010);
    end
    i_cmd = 6'b000001;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000000) begin
      n_bad++;
      $display("FAIL zero_dead_b: got %b want %b", o_gate, 6'b000000);
    end
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000001) begin
      n_bad++;
      $display("FAIL zero_low: got %b want %b", o_gate, 6'b000001);
    end
    i_cmd = 6'b000000;
    tick(2);
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL zero_off: got gate %b ready %b want 000000 111", o_gate, o_ready);
    end
  endtask

  task automatic test_illegal();
    i_deadtime = 8'd3;
    i_cmd = 6'b001000;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b001000) begin
      n_bad++;
      $display("FAIL ill_high: got %b want %b", o_gate, 6'b001000);
    end
    i_cmd = 6'b001100;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b101 || o_fault !== 3'b010) begin
      n_bad++;
      $display("FAIL ill_dead: got gate %b ready %b fault %b want 000000 101 010", o_gate, o_ready, o_fault);
    end
    tick(2);
    n_cmp++;
    if (o_ready !== 3'b101) begin
      n_bad++;
      $display("FAIL ill_still_dead: got ready %b want 101", o_ready);
    end
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL ill_off: got gate %b ready %b want 000000 111", o_gate, o_ready);
    end
    i_cmd = 6'b000000;
    tick(1);
    n_cmp++;
    if (o_fault !== 3'b010) begin
      n_bad++;
      $display("FAIL ill_sticky: got %b want %b", o_fault, 3'b010);
    end
    i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    n_cmp++;
    if (o_fault !== 3'b000) begin
      n_bad++;
      $display("FAIL ill_clear: got %b want %b", o_fault, 3'b000);
    end
    i_cmd = 6'b001100;
    i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    i_cmd = 6'b000000;
    n_cmp++;
    if (o_fault !== 3'b010 || o_gate !== 6'b000000) begin
      n_bad++;
      $display("FAIL ill_set_wins: got fault %b gate %b want 010 000000", o_fault, o_gate);
    end
    i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    n_cmp++;
    if (o_fault !== 3'b000) begin
      n_bad++;
      $display("FAIL ill_clear2: got %b want %b", o_fault, 3'b000);
    end
  endtask

  task automatic test_mid_dead_change();
    i_deadtime = 8'd10;
    i_cmd = 6'b000010;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000010) begin
      n_bad++;
      $display("FAIL mid_high: got %b want %b", o_gate, 6'b000010);
    end
    i_cmd = 6'b000001;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
    end
    // Dead-time input changes here must not affect the running count.
    i_cmd = 6'b000010;
    i_deadtime = 8'd2;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_cmp++;
      if (o_gate !== 6'b000000 || o_ready !== 3'b110) begin
        n_bad++;
        $display("FAIL mid_dead[%0d]: got gate %b ready %b want 000000 110", i, o_gate, o_ready);
      end
    end
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000010 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_final: got gate %b ready %b want 000010 111", o_gate, o_ready);
    end
  endtask

  task automatic test_reset_enable();
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b000010) begin
      n_bad++;
      $display("FAIL hold_high: got %b want %b", o_gate, 6'b000010);
    end
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL rst_high: got gate %b ready %b want 000000 111", o_gate, o_ready);
    end
    i_deadtime = 8'd4;
    i_cmd = 6'b010010;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b010010) begin
      n_bad++;
      $display("FAIL en_on: got %b want %b", o_gate, 6'b010010);
    end
    i_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_cmp++;
      if (o_gate !== 6'b000000 || o_ready !== 3'b010) begin
        n_bad++;
        $display("FAIL dis_dead[%0d]: got gate %b ready %b want 000000 010", i, o_gate, o_ready);
      end
    end
    tick(2);
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL dis_off: got gate %b ready %b want 000000 111", o_gate, o_ready);
    end
    i_enable = 1'b1;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b010010) begin
      n_bad++;
      $display("FAIL reen: got %b want %b", o_gate, 6'b010010);
    end
    i_cmd = 6'b010001;
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b010000 || o_ready !== 3'b110) begin
      n_bad++;
      $display("FAIL pre_rst_dead: got gate %b ready %b want 010000 110", o_gate, o_ready);
    end
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    n_cmp++;
    if (o_gate !== 6'b000000 || o_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL rst_dead: got gate %b ready %b want 000000 111", o_gate, o_ready);
    end
    tick(1);
    n_cmp++;
    if (o_gate !== 6'b010001) begin
      n_bad++;
      $display("FAIL post_rst: got %b want %b", o_gate, 6'b010001);
    end
  endtask

  task automatic test_stress();
    logic [1:0] prev [3];
    int         off_run [3];
    int         need [3];
    bit         armed [3];
    int         dt_applied;
    logic [1:0] cur;
    for (int k = 0; k < 3; k++) begin
      prev[k] = o_gate[2*k+:2];
      off_run[k] = 0;
      need[k] = 0;
      armed[k] = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) i_cmd = 6'($urandom_range(0, 63));
      i_deadtime = 8'($urandom_range(0, 7));
      i_enable = ($urandom_range(0, 19) != 0);
      dt_applied = int'(i_deadtime);
      tick(1);
      for (int k = 0; k < 3; k++) begin
        cur = o_gate[2*k+:2];
        n_cmp++;
        if (cur === 2'b11) begin
          n_bad++;
          $display("FAIL stress_shoot[%0d] cyc %0d: got %b want not 11", k, c, cur);
        end
        if (cur == 2'b00) begin
          if (prev[k] != 2'b00) begin
            armed[k] = 1'b1;
            off_run[k] = 1;
            need[k] = (dt_applied == 0) ? 1 : dt_applied;
          end else begin
            off_run[k]++;
          end
        end else if (prev[k] == 2'b00) begin
          if (armed[k]) begin
            n_cmp++;
            if (off_run[k] < need[k]) begin
              n_bad++;
              $display("FAIL stress_dead[%0d] cyc %0d: got %0d off want >= %0d", k, c, off_run[k], need[k]);
            end
            armed[k] = 1'b0;
          end
        end else if (cur != prev[k]) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stress_nodead[%0d] cyc %0d: got %b after %b want 00 between", k, c, cur, prev[k]);
        end
        prev[k] = cur;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rst = 1'b1;
    i_cmd = 6'b0;
    i_deadtime = 8'd0;
    i_enable = 1'b1;
    i_fault_clr = 1'b0;
    test_reset();
    test_basic_switch();
    test_zero_deadtime();
    test_illegal();
    test_mid_dead_change();
    test_reset_enable();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
